// File: rtl/sht30_pkg.sv
// Shared constants, FSM state type and CRC-8 step function for the SHT30
// result decoder.
package sht30_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h31;
   localparam logic [7:0] CRC8_INIT = 8'hFF;

   localparam int unsigned T_SCALE  = 175;
   localparam int unsigned T_OFFSET = 45;
   localparam int unsigned RH_SCALE = 100;

   localparam int unsigned CRC_CYCLES = 16;
   localparam int unsigned MUL_CYCLES = 16;
   localparam int unsigned DIV_CYCLES = 10;

   typedef enum logic [2:0] {
      IDLE,
      CRC,
      MUL,
      ADJ,
      DIV,
      DONE
   } state_t;

   // One MSB-first CRC-8 step: feedback is the outgoing MSB xor the new bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/sht30_result_decoder_if.sv
// Handshake and result bundle between the I2C read phase (master) and the
// result decoder (slave), which in turn feeds the LCD write phase.
interface sht30_result_decoder_if;

   logic        start;
   logic [47:0] rdata;
   logic        busy;
   logic        done;
   logic        crc_ok_t;
   logic        crc_ok_h;
   logic        temp_neg;
   logic        temp_over;
   logic [3:0]  temp_ten;
   logic [3:0]  temp_one;
   logic [3:0]  humi_ten;
   logic [3:0]  humi_one;

   modport master (
      output start, rdata,
      input  busy, done, crc_ok_t, crc_ok_h, temp_neg, temp_over,
             temp_ten, temp_one, humi_ten, humi_one
   );

   modport slave (
      input  start, rdata,
      output busy, done, crc_ok_t, crc_ok_h, temp_neg, temp_over,
             temp_ten, temp_one, humi_ten, humi_one
   );

endinterface

// File: rtl/sht30_crc8.sv
// Bit-serial CRC-8 (poly 0x31, init 0xFF, no final xor), one data bit per
// shift cycle, MSB first.
module sht30_crc8
   import sht30_pkg::*;
(
   input  logic       clk_50K,
   input  logic       rstn,
   input  logic       load,
   input  logic       shift,
   input  logic       data_in,
   output logic [7:0] crc_out
);

   // CRC register: load seeds the init value, shift absorbs one bit.
   always_ff @(posedge clk_50K or negedge rstn) begin
      if (!rstn) begin
         crc_out <= '0;
      end else if (load) begin
         crc_out <= CRC8_INIT;
      end else if (shift) begin
         crc_out <= crc8_step(crc_out, data_in);
      end
   end

endmodule

// File: rtl/sht30_result_decoder.sv
// Sequential SHT30 post-processor: checks both CRC bytes, scales raw
// temperature/humidity with a shift-add multiply and converts them to two
// BCD digits each by repeated subtraction. Fixed 44-cycle latency.
module sht30_result_decoder
   import sht30_pkg::*;
(
   input  logic                   clk_50K,
   input  logic                   rstn,
   sht30_result_decoder_if.slave  bus
);

   localparam logic [4:0] CRC_LAST = 5'(CRC_CYCLES - 1);
   localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

   state_t      state;
   logic [4:0]  phase;        // shared sequencer for CRC, MUL and DIV
   logic [47:0] frame;
   logic [23:0] pt;
   logic [23:0] ph;
   logic [6:0]  mag;
   logic [6:0]  hum;
   logic [3:0]  tens_t;
   logic [3:0]  tens_h;
   logic        ok_t;
   logic        ok_h;
   logic        neg;
   logic        over;

   logic [15:0] st;
   logic [15:0] srh;
   logic [7:0]  crc_t;
   logic [7:0]  crc_h;
   logic        crc_load;
   logic        crc_shift;

   logic signed [8:0] t_s;
   logic        [8:0] t_abs;
   logic              t_over;
   logic        [6:0] mag_next;

   assign st        = frame[47:32];
   assign srh       = frame[23:8];
   assign crc_load  = (state == IDLE) && bus.start;
   assign crc_shift = (state == CRC);

   // MSB-first feed: bit (15 - phase) is simply the inverted phase index.
   sht30_crc8 u_crc_t (
      .clk_50K (clk_50K),
      .rstn    (rstn),
      .load    (crc_load),
      .shift   (crc_shift),
      .data_in (st[~phase[3:0]]),
      .crc_out (crc_t)
   );

   sht30_crc8 u_crc_h (
      .clk_50K (clk_50K),
      .rstn    (rstn),
      .load    (crc_load),
      .shift   (crc_shift),
      .data_in (srh[~phase[3:0]]),
      .crc_out (crc_h)
   );

   // Offset removal, sign/magnitude split and saturation for the ADJ cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      t_s      = $signed({1'b0, pt[23:16]}) - $signed(9'(T_OFFSET));
      t_abs    = t_s[8] ? 9'(-t_s) : 9'(t_s);
      t_over   = (t_abs > 9'd99);
      mag_next = t_over ? 7'd99 : t_abs[6:0];
   end

   // Main sequencer: capture, CRC, multiply, adjust, divide, publish.
   always_ff @(posedge clk_50K or negedge rstn) begin
      // NOTE: all state including the datapath registers is reset, so an abort clears everything.
      if (!rstn) begin
         state         <= IDLE;
         phase         <= '0;
         frame         <= '0;
         pt            <= '0;
         ph            <= '0;
         mag           <= '0;
         hum           <= '0;
         tens_t        <= '0;
         tens_h        <= '0;
         ok_t          <= 1'b0;
         ok_h          <= 1'b0;
         neg           <= 1'b0;
         over          <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.crc_ok_t  <= 1'b0;
         bus.crc_ok_h  <= 1'b0;
         bus.temp_neg  <= 1'b0;
         bus.temp_over <= 1'b0;
         bus.temp_ten  <= '0;
         bus.temp_one  <= '0;
         bus.humi_ten  <= '0;
         bus.humi_one  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  frame    <= bus.rdata;
                  bus.busy <= 1'b1;
                  phase    <= '0;
                  pt       <= '0;
                  ph       <= '0;
                  tens_t   <= '0;
                  tens_h   <= '0;
                  state    <= CRC;
               end
            end

            CRC: begin
               if (phase == CRC_LAST) begin
                  phase <= '0;
                  state <= MUL;
               end else begin
                  phase <= phase + 5'd1;
               end
            end

            MUL: begin
               if (st[phase[3:0]])
                  pt <= pt + (24'(T_SCALE) << phase[3:0]);
               if (srh[phase[3:0]])
                  ph <= ph + (24'(RH_SCALE) << phase[3:0]);
               if (phase == MUL_LAST) begin
                  phase <= '0;
                  state <= ADJ;
               end else begin
                  phase <= phase + 5'd1;
               end
            end

            ADJ: begin
               // CRC registers have been stable since the last CRC shift.
               ok_t  <= (crc_t == frame[31:24]);
               ok_h  <= (crc_h == frame[7:0]);
               neg   <= t_s[8];
               over  <= t_over;
               mag   <= mag_next;
               hum   <= ph[22:16];   // 100*Srh/65536 never exceeds 99
               phase <= '0;
               state <= DIV;
            end

            DIV: begin
               if (mag >= 7'd10) begin
                  mag    <= mag - 7'd10;
                  tens_t <= tens_t + 4'd1;
               end
               if (hum >= 7'd10) begin
                  hum    <= hum - 7'd10;
                  tens_h <= tens_h + 4'd1;
               end
               if (phase == DIV_LAST) begin
                  phase <= '0;
                  state <= DONE;
               end else begin
                  phase <= phase + 5'd1;
               end
            end

            DONE: begin
               bus.crc_ok_t  <= ok_t;
               bus.crc_ok_h  <= ok_h;
               bus.temp_neg  <= neg;
               bus.temp_over <= over;
               bus.temp_ten  <= tens_t;
               bus.temp_one  <= mag[3:0];
               bus.humi_ten  <= tens_h;
               bus.humi_one  <= hum[3:0];
               bus.done      <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sht30_result_decoder.sv
// Scoreboard bench for sht30_result_decoder: stimulus pushes hand-computed
// results, an independent monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_sht30_result_decoder;

   localparam int LATENCY = 44;

   typedef struct {
      int       acc_cyc;
      logic     ok_t;
      logic     ok_h;
      logic     neg;
      logic     over;
      logic [3:0] tt;
      logic [3:0] to;
      logic [3:0] ht;
      logic [3:0] ho;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];
   logic prev_done = 1'b0;

   sht30_result_decoder_if bus ();

   sht30_result_decoder dut (
      .clk_50K (clk),
      .rstn    (rstn),
      .bus     (bus)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_done"},  32'(bus.done), 32'd0);
      check({tag, "_flags"}, 32'({bus.crc_ok_t, bus.crc_ok_h, bus.temp_neg, bus.temp_over}), 32'd0);
      check({tag, "_digits"}, 32'({bus.temp_ten, bus.temp_one, bus.humi_ten, bus.humi_one}), 32'd0);
   endtask

   // Drive one start pulse from the current (negedge) point; push expectation if accepted.
   task automatic issue(input logic [47:0] frame, input logic push, input exp_t e);
      exp_t x;
      x = e;
      bus.rdata = frame;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      if (push) begin
         x.acc_cyc = cyc;
         q.push_back(x);
      end
   endtask

   // Wait for done, returning at the negedge where done is seen.
   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LATENCY + 20; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic exp_t mk(input logic ok_t, ok_h, neg, over,
                               input logic [3:0] tt, to, ht, ho);
      exp_t e;
      e.acc_cyc = 0;
      e.ok_t = ok_t; e.ok_h = ok_h; e.neg = neg; e.over = over;
      e.tt = tt; e.to = to; e.ht = ht; e.ho = ho;
      return e;
   endfunction

   // Monitor: compare every done pulse against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && bus.done) begin
            check("done_single_pulse", 32'(prev_done), 32'd0);
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("latency",   32'(cyc - e.acc_cyc), 32'(LATENCY));
               check("busy_at_done", 32'(bus.busy), 32'd0);
               check("crc_ok_t",  32'(bus.crc_ok_t),  32'(e.ok_t));
               check("crc_ok_h",  32'(bus.crc_ok_h),  32'(e.ok_h));
               check("temp_neg",  32'(bus.temp_neg),  32'(e.neg));
               check("temp_over", 32'(bus.temp_over), 32'(e.over));
               check("temp_ten",  32'(bus.temp_ten),  32'(e.tt));
               check("temp_one",  32'(bus.temp_one),  32'(e.to));
               check("humi_ten",  32'(bus.humi_ten),  32'(e.ht));
               check("humi_one",  32'(bus.humi_one),  32'(e.ho));
            end
         end
         prev_done = bus.done;
      end
   end

   localparam logic [47:0] F_NOM  = {16'hBEEF, 8'h92, 16'hBEEF, 8'h92};
   localparam logic [47:0] F_BADT = {16'hBEEF, 8'h93, 16'hBEEF, 8'h92};
   localparam logic [47:0] F_ZERO = {16'h0000, 8'h81, 16'h0000, 8'h81};
   localparam logic [47:0] F_FULL = {16'hFFFF, 8'hAC, 16'hFFFF, 8'h00};

   initial begin
      exp_t e_nom, e_badt, e_zero, e_full, e_none;
      int   dones;
      // 175*0xBEEF>>16 = 130 -> 85 C; 100*0xBEEF>>16 = 74 %
      e_nom  = mk(1, 1, 0, 0, 4'd8, 4'd5, 4'd7, 4'd4);
      e_badt = mk(0, 1, 0, 0, 4'd8, 4'd5, 4'd7, 4'd4);
      // raw 0 -> -45 C, 0 %; CRC(0x0000) = 0x81
      e_zero = mk(1, 1, 1, 0, 4'd4, 4'd5, 4'd0, 4'd0);
      // raw 0xFFFF -> 174-45 = 129 C saturated, 99 %; CRC(0xFFFF) = 0xAC
      e_full = mk(1, 0, 0, 1, 4'd9, 4'd9, 4'd9, 4'd9);
      e_none = mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);

      bus.start = 1'b0;
      bus.rdata = '0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Directed frames, back to back.
      issue(F_NOM, 1'b1, e_nom);   wait_done("nom");
      @(negedge clk);
      issue(F_BADT, 1'b1, e_badt); wait_done("badt");
      @(negedge clk);
      issue(F_ZERO, 1'b1, e_zero); wait_done("zero");
      @(negedge clk);
      issue(F_FULL, 1'b1, e_full); wait_done("full");

      // Start at E10 must be ignored; start in the done cycle must be accepted.
      @(negedge clk);
      issue(F_NOM, 1'b1, e_nom);
      repeat (9) @(posedge clk);
      #5;
      bus.rdata = F_ZERO;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_ignored_start", 32'(bus.busy), 32'd1);
      wait_done("overlap");
      issue(F_FULL, 1'b1, e_full);
      wait_done("done_cycle_start");

      // Mid-operation reset clears everything and produces no done.
      @(negedge clk);
      issue(F_NOM, 1'b1, e_nom);
      repeat (20) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero("async_reset");
      q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      dones = 0;
      for (int i = 0; i < LATENCY + 10; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("no_done_after_reset", 32'(dones), 32'd0);
      check_all_zero("idle_after_reset");

      @(negedge clk);
      issue(F_NOM, 1'b1, e_nom);
      wait_done("after_reset");

      @(negedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      check("digits_hold", 32'({bus.temp_ten, bus.temp_one, bus.humi_ten, bus.humi_one}),
            32'({e_nom.tt, e_nom.to, e_nom.ht, e_nom.ho}));
      if (e_none.ok_t) $display("note: unused");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
